// File: rtl/draw_processor_pkg.sv
// rtl/draw_processor_pkg.sv - shared constants, types and address helper for the draw processor
package draw_processor_pkg;

    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;
    localparam int X_W           = 8;
    localparam int Y_W           = 7;
    localparam int COLOUR_W      = 3;
    localparam int INSTR_W       = 32;
    localparam int RESULT_W      = 32;
    localparam int ADDR_W        = 15;
    localparam int FB_DEPTH      = SCREEN_WIDTH * SCREEN_HEIGHT;

    localparam int OP_LSB     = 28;
    localparam int PLOT_BIT   = 18;
    localparam int COLOUR_LSB = 15;
    localparam int Y_LSB      = 8;
    localparam int X_LSB      = 0;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PLOT = 4'd1;
    localparam logic [3:0] OP_FILL = 4'd2;
    localparam logic [3:0] OP_READ = 4'd3;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_BADOP = 2'b01;
    localparam logic [1:0] ST_RANGE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC_PLOT,
        S_EXEC_FILL,
        S_READ_ADDR,
        S_READ_DATA,
        S_ERR,
        S_NOP,
        S_DONE
    } state_t;

    // y*160 + x built from shifts so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] y_ext;
        y_ext = {{(ADDR_W-Y_W){1'b0}}, y};
        return (y_ext << 7) + (y_ext << 5) + {{(ADDR_W-X_W){1'b0}}, x};
    endfunction

endpackage

// File: rtl/draw_processor_framebuffer_shadow.sv
// rtl/draw_processor_framebuffer_shadow.sv - single-port shadow framebuffer, 1-cycle read, write-first
module framebuffer_shadow
    import draw_processor_pkg::*;
(
    input  logic                clock,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [COLOUR_W-1:0] wdata,
    output logic [COLOUR_W-1:0] rdata
);

    logic [COLOUR_W-1:0] mem [0:FB_DEPTH-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/draw_processor.sv
// rtl/draw_processor.sv - decodes one draw instruction, drives the VGA write port and shadow framebuffer
module draw_processor
    import draw_processor_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [INSTR_W-1:0]  instruction,
    output logic                finished,
    output logic [RESULT_W-1:0] result,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    state_t state, state_nxt;

    logic                armed;
    logic [3:0]          op_in;
    logic                plot_in;
    logic [COLOUR_W-1:0] colour_in;
    logic [Y_W-1:0]      y_in;
    logic [X_W-1:0]      x_in;
    logic                in_range;
    logic                accept;
    logic                unused_rsvd;

    logic                plot_q;
    logic [COLOUR_W-1:0] colour_q;
    logic [Y_W-1:0]      y_q;
    logic [X_W-1:0]      x_q;
    logic [1:0]          status_q;
    logic [1:0]          status_in;
    logic [X_W-1:0]      fill_x;
    logic [Y_W-1:0]      fill_y;
    logic                fill_last;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [COLOUR_W-1:0] ram_wdata;
    logic [COLOUR_W-1:0] ram_rdata;

    assign op_in       = instruction[OP_LSB +: 4];
    assign plot_in     = instruction[PLOT_BIT];
    assign colour_in   = instruction[COLOUR_LSB +: COLOUR_W];
    assign y_in        = instruction[Y_LSB +: Y_W];
    assign x_in        = instruction[X_LSB +: X_W];
    assign unused_rsvd = ^instruction[27:19];

    assign in_range  = (x_in < X_W'(SCREEN_WIDTH)) && (y_in < Y_W'(SCREEN_HEIGHT));
    assign accept    = (state == S_IDLE) && start && armed;
    assign fill_last = (fill_x == X_W'(SCREEN_WIDTH - 1)) && (fill_y == Y_W'(SCREEN_HEIGHT - 1));
    assign finished  = (state == S_IDLE) || (state == S_DONE);

    always_comb begin
        status_in = ST_OK;
        if (op_in > OP_READ)
            status_in = ST_BADOP;
        else if ((op_in == OP_PLOT || op_in == OP_READ) && !in_range)
            status_in = ST_RANGE;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            result   <= '0;
            plot_q   <= 1'b0;
            colour_q <= '0;
            y_q      <= '0;
            x_q      <= '0;
            status_q <= ST_OK;
            fill_x   <= '0;
            fill_y   <= '0;
        end else begin
            state <= state_nxt;

            if (accept)
                armed <= 1'b0;
            else if (!start)
                armed <= 1'b1;

            if (accept) begin
                plot_q   <= plot_in;
                colour_q <= colour_in;
                y_q      <= y_in;
                x_q      <= x_in;
                status_q <= status_in;
                fill_x   <= '0;
                fill_y   <= '0;
            end else if (state == S_EXEC_FILL) begin
                if (fill_x == X_W'(SCREEN_WIDTH - 1)) begin
                    fill_x <= '0;
                    fill_y <= fill_y + 1'b1;
                end else begin
                    fill_x <= fill_x + 1'b1;
                end
            end

            // Result is only updated on the way into DONE so it holds while idle
            if (state_nxt == S_DONE && state != S_DONE)
                result <= {status_q, 27'b0, (state == S_READ_DATA) ? ram_rdata : {COLOUR_W{1'b0}}};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (status_in != ST_OK)
                        state_nxt = S_ERR;
                    else begin
                        case (op_in)
                            OP_PLOT: state_nxt = S_EXEC_PLOT;
                            OP_FILL: state_nxt = S_EXEC_FILL;
                            OP_READ: state_nxt = S_READ_ADDR;
                            default: state_nxt = S_NOP;
                        endcase
                    end
                end
            end
            S_EXEC_FILL: if (fill_last) state_nxt = S_DONE;
            S_READ_ADDR: state_nxt = S_READ_DATA;
            S_EXEC_PLOT,
            S_READ_DATA,
            S_ERR,
            S_NOP:       state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        case (state)
            S_EXEC_PLOT: begin
                vga_x      = x_q;
                vga_y      = y_q;
                vga_colour = colour_q;
                vga_plot   = plot_q;
                ram_we     = 1'b1;
                ram_addr   = pixel_addr(x_q, y_q);
                ram_wdata  = colour_q;
            end
            S_EXEC_FILL: begin
                vga_x      = fill_x;
                vga_y      = fill_y;
                vga_colour = colour_q;
                vga_plot   = plot_q;
                ram_we     = 1'b1;
                ram_addr   = pixel_addr(fill_x, fill_y);
                ram_wdata  = colour_q;
            end
            S_READ_ADDR: ram_addr = pixel_addr(x_q, y_q);
            default: ;
        endcase
    end

    framebuffer_shadow u_framebuffer_shadow (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
